cache_mem_arbiter: RTL and testbench

//  Arbitrates the single-ported RAM between the instruction cache (iREN/iaddr) and data cache (dREN/dWEN/daddr).

---
 rtl/cache_mem_arbiter_if.sv | 33 +++
 rtl/cache_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM signals seen by cache_mem_arbiter.
//   slave  : arbiter side (takes requests and RAM responses, returns waits, loads and RAM commands)
//   master : requester/RAM side (the caches and the RAM model)
// Signal names follow the existing cache/RAM port names so the arbiter drops
// straight into the memory subsystem.
interface cache_mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single-ported RAM between the icache and the
// dcache miss ports. A registered grant selects one owner per transaction and
// holds it until the RAM reports ACCESS; everyone else sees wait=1.
//
// Ports
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : cache_mem_arbiter_if.slave (icache, dcache and RAM signals)
//
// Build option
//   ARB_STARVE_GUARD_EN : when defined, adds parameter STARVE_LIMIT (default 4)
//   and a counter that forces the icache through after STARVE_LIMIT consecutive
//   data completions while iREN was pending. Undefined: strict data priority.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; RAM enables 0; one IDLE cycle between transactions
// IGNT  | icache owns the RAM; read of iaddr until ACCESS or iREN drop
// DGNT  | dcache owns the RAM; write wins over read when both asserted
module cache_mem_arbiter
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
   input logic                CLK,
   input logic                nRST,
   cache_mem_arbiter_if.slave bus
);

   localparam logic [1:0] RAM_ACCESS = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   dreq;
   logic   access;
   logic   starved;

   assign dreq   = bus.dREN | bus.dWEN;
   assign access = (bus.ramstate == RAM_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned     SCNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

   logic [SCNT_W-1:0] scnt_q, scnt_d;

   assign starved = (scnt_q == SCNT_MAX) & bus.iREN;

   always_comb begin
      scnt_d = scnt_q;
      if ((state_q == DGNT) && dreq && access && bus.iREN) begin
         if (scnt_q != SCNT_MAX) scnt_d = scnt_q + 1'b1;
      end else if (((state_q == IGNT) && bus.iREN && access) ||
                   ((state_q == IDLE) && !bus.iREN)) begin
         scnt_d = '0;
      end
   end
`else
   assign starved = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // starvation override first, then fixed data priority
            if (starved)       state_d = IGNT;
            else if (dreq)     state_d = DGNT;
            else if (bus.iREN) state_d = IGNT;
         end
         IGNT:    if (!bus.iREN || access) state_d = IDLE;
         DGNT:    if (!dreq || access)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
         scnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef ARB_STARVE_GUARD_EN
         scnt_q  <= scnt_d;
`endif
      end
   end

   // RAM command and requester responses decode from the registered owner.
   // A dropped request aborts in the same cycle: nothing is driven and no
   // completion is reported even if the RAM happens to answer ACCESS.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = '0;
      bus.dload    = '0;
      unique case (state_q)
         IGNT: begin
            if (bus.iREN) begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.iaddr;
               if (access) begin
                  bus.iwait = 1'b0;
                  bus.iload = bus.ramload;
               end
            end
         end
         DGNT: begin
            if (dreq) begin
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = bus.dREN & ~bus.dWEN;
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               if (access) begin
                  bus.dwait = 1'b0;
                  bus.dload = bus.ramload;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

   localparam logic [1:0] FR = 2'b00;
   localparam logic [1:0] BZ = 2'b01;
   localparam logic [1:0] AC = 2'b10;
   localparam logic [1:0] ER = 2'b11;

   typedef struct {
      logic        iren;
      logic        dren;
      logic        dwen;
      logic [1:0]  rst;
      logic [31:0] rload;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic        e_iwait;
      logic        e_dwait;
      logic [31:0] e_iload;
      logic [31:0] e_dload;
   } vec_t;

   logic clk;
   logic nrst;
   int   n_tests;
   int   n_fail;
   vec_t vecs[22];

   cache_mem_arbiter_if bus();

   cache_mem_arbiter dut (
      .CLK  (clk),
      .nRST (nrst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic iren, input logic dren, input logic dwen,
                              input logic [1:0] rst, input logic [31:0] rload,
                              input logic e_ren, input logic e_wen,
                              input logic [31:0] e_addr, input logic [31:0] e_store,
                              input logic e_iwait, input logic e_dwait,
                              input logic [31:0] e_iload, input logic [31:0] e_dload);
      vec_t r;
      r.iren = iren; r.dren = dren; r.dwen = dwen; r.rst = rst; r.rload = rload;
      r.e_ren = e_ren; r.e_wen = e_wen; r.e_addr = e_addr; r.e_store = e_store;
      r.e_iwait = e_iwait; r.e_dwait = e_dwait; r.e_iload = e_iload; r.e_dload = e_dload;
      return r;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, ".ramREN"}, 32'(bus.ramREN), 32'd0);
      check({tag, ".ramWEN"}, 32'(bus.ramWEN), 32'd0);
      check({tag, ".iwait"},  32'(bus.iwait),  32'd1);
      check({tag, ".dwait"},  32'(bus.dwait),  32'd1);
   endtask

   initial begin
      int dcomp;
      int icomp;
      int dbefore;
      bit seen_i;

      n_tests = 0;
      n_fail  = 0;

      // one cycle per row: inputs applied just after the edge, outputs checked 1ns later
      //          iR dR dW  ram  ramload        REN WEN addr   store      iw dw iload         dload
      vecs[0]  = v(1, 0, 0, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[1]  = v(1, 0, 0, BZ, 32'h0,          1, 0, 32'h40, 32'h0,     1, 1, 32'h0,        32'h0);
      vecs[2]  = v(1, 0, 0, BZ, 32'h0,          1, 0, 32'h40, 32'h0,     1, 1, 32'h0,        32'h0);
      vecs[3]  = v(1, 0, 0, AC, 32'hDEADBEEF,   1, 0, 32'h40, 32'h0,     0, 1, 32'hDEADBEEF, 32'h0);
      vecs[4]  = v(0, 0, 0, FR, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[5]  = v(1, 1, 0, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[6]  = v(1, 1, 0, AC, 32'hCAFEF00D,   1, 0, 32'h80, 32'h1234,  1, 0, 32'h0,        32'hCAFEF00D);
      vecs[7]  = v(1, 0, 0, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[8]  = v(1, 0, 0, AC, 32'h11111111,   1, 0, 32'h40, 32'h0,     0, 1, 32'h11111111, 32'h0);
      vecs[9]  = v(0, 0, 0, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[10] = v(0, 1, 1, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[11] = v(0, 1, 1, ER, 32'h0,          0, 1, 32'h80, 32'h1234,  1, 1, 32'h0,        32'h0);
      vecs[12] = v(0, 1, 1, ER, 32'h0,          0, 1, 32'h80, 32'h1234,  1, 1, 32'h0,        32'h0);
      vecs[13] = v(0, 1, 1, ER, 32'h0,          0, 1, 32'h80, 32'h1234,  1, 1, 32'h0,        32'h0);
      vecs[14] = v(0, 1, 1, AC, 32'h55,         0, 1, 32'h80, 32'h1234,  1, 0, 32'h0,        32'h55);
      vecs[15] = v(0, 1, 1, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[16] = v(0, 1, 1, BZ, 32'h0,          0, 1, 32'h80, 32'h1234,  1, 1, 32'h0,        32'h0);
      vecs[17] = v(0, 0, 0, BZ, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[18] = v(1, 0, 0, FR, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[19] = v(1, 0, 0, BZ, 32'h0,          1, 0, 32'h40, 32'h0,     1, 1, 32'h0,        32'h0);
      vecs[20] = v(0, 0, 0, BZ, 32'h0,          0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);
      vecs[21] = v(0, 0, 0, AC, 32'h77,         0, 0, 32'h0,  32'h0,     1, 1, 32'h0,        32'h0);

      // reset with requests already asserted
      nrst         = 1'b0;
      bus.iREN     = 1'b1;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b1;
      bus.iaddr    = 32'h40;
      bus.daddr    = 32'h80;
      bus.dstore   = 32'h1234;
      bus.ramload  = 32'h0;
      bus.ramstate = FR;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      nrst = 1'b1;
      #1;
      check_idle("post_reset_idle");
      @(posedge clk); #1;
      check("first_grant.ramWEN", 32'(bus.ramWEN), 32'd1);
      check("first_grant.ramaddr", bus.ramaddr, 32'h80);
      check("first_grant.ramstore", bus.ramstore, 32'h1234);
      check("first_grant.iwait", 32'(bus.iwait), 32'd1);
      bus.dWEN = 1'b0;
      bus.iREN = 1'b0;
      #1;
      check_idle("first_grant_abort");

      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         bus.iREN     = vecs[i].iren;
         bus.dREN     = vecs[i].dren;
         bus.dWEN     = vecs[i].dwen;
         bus.ramstate = vecs[i].rst;
         bus.ramload  = vecs[i].rload;
         #1;
         check($sformatf("row%0d.ramREN", i),   32'(bus.ramREN),  32'(vecs[i].e_ren));
         check($sformatf("row%0d.ramWEN", i),   32'(bus.ramWEN),  32'(vecs[i].e_wen));
         check($sformatf("row%0d.ramaddr", i),  bus.ramaddr,      vecs[i].e_addr);
         check($sformatf("row%0d.ramstore", i), bus.ramstore,     vecs[i].e_store);
         check($sformatf("row%0d.iwait", i),    32'(bus.iwait),   32'(vecs[i].e_iwait));
         check($sformatf("row%0d.dwait", i),    32'(bus.dwait),   32'(vecs[i].e_dwait));
         check($sformatf("row%0d.iload", i),    bus.iload,        vecs[i].e_iload);
         check($sformatf("row%0d.dload", i),    bus.dload,        vecs[i].e_dload);
      end

      // reset pulse in the middle of a BUSY icache read
      @(posedge clk); #1;
      bus.iREN     = 1'b1;
      bus.ramstate = FR;
      @(posedge clk); #1;
      bus.ramstate = BZ;
      #1;
      check("rst_mid.granted.ramREN", 32'(bus.ramREN), 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      check("rst_mid.async.ramREN", 32'(bus.ramREN), 32'd0);
      check("rst_mid.async.ramaddr", bus.ramaddr, 32'h0);
      check("rst_mid.async.iwait", 32'(bus.iwait), 32'd1);
      @(posedge clk); #1;
      bus.ramstate = AC;
      bus.ramload  = 32'h99;
      #1;
      check("rst_mid.held.iwait", 32'(bus.iwait), 32'd1);
      check("rst_mid.held.iload", bus.iload, 32'h0);
      nrst = 1'b1;
      #1;
      check("rst_mid.release.ramREN", 32'(bus.ramREN), 32'd0);
      @(posedge clk); #1;
      check("rst_mid.regrant.ramREN", 32'(bus.ramREN), 32'd1);
      check("rst_mid.regrant.iwait", 32'(bus.iwait), 32'd0);
      check("rst_mid.regrant.iload", bus.iload, 32'h99);
      @(posedge clk); #1;
      bus.iREN     = 1'b0;
      bus.ramstate = FR;

      // starvation: icache and dcache both requesting, RAM answers at once
      @(posedge clk); #1;
      bus.iREN     = 1'b1;
      bus.dREN     = 1'b1;
      bus.ramstate = AC;
      bus.ramload  = 32'hAA;
      dcomp   = 0;
      icomp   = 0;
      dbefore = 0;
      seen_i  = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!bus.dwait) dcomp++;
         if (!bus.iwait) begin
            icomp++;
            if (!seen_i) dbefore = dcomp;
            seen_i = 1'b1;
         end
         @(posedge clk); #1;
      end
`ifdef ARB_STARVE_GUARD_EN
      check("starve.icache_served", 32'(seen_i), 32'd1);
      check("starve.data_before_i", 32'(dbefore), 32'd4);
`else
      check("starve.icache_served", 32'(icomp), 32'd0);
      check("starve.data_completions", 32'(dcomp), 32'd20);
`endif
      bus.iREN     = 1'b0;
      bus.dREN     = 1'b0;
      bus.ramstate = FR;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
